// File: rtl/addr_cnt_sched_pkg.sv
// Shared definitions for the address-counter scheduler: FSM encoding,
// requester indices and a small index-to-grant helper.
package addr_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/addr_cnt_sched_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// the requester that was not granted last.
module rr_arb2
  import addr_cnt_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // combinational one-hot winner selection
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = idx_to_onehot((last == REQ0) ? REQ1 : REQ0);
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/addr_cnt_sched.sv
// Shares one address Counter between two requesters: grants round-robin,
// enables the Counter for the winner's burst length, then clears it.
module addr_cnt_sched
  import addr_cnt_pkg::*;
#(
  parameter int CNT_WIDTH = 7
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           req_i,
  input  logic [CNT_WIDTH-1:0] len0_i,
  input  logic [CNT_WIDTH-1:0] len1_i,
  output logic [1:0]           gnt_o,
  output logic                 cnt_en_o,
  output logic                 cnt_done_o,
  output logic [1:0]           done_o,
  output logic                 busy_o
);

  localparam logic [CNT_WIDTH-1:0] LEN_ZERO = CNT_WIDTH'(0);
  localparam logic [CNT_WIDTH-1:0] LEN_ONE  = CNT_WIDTH'(1);

  state_e               state_r, state_s;
  logic [1:0]           gnt_r, gnt_s;
  logic [CNT_WIDTH-1:0] len_r, len_s;
  logic [CNT_WIDTH-1:0] beat_r, beat_s;
  logic                 last_r, last_s;
  logic [1:0]           arb_gnt_s;
  logic                 cnt_en_r, cnt_en_s;
  logic                 cnt_done_r, cnt_done_s;
  logic [1:0]           done_r, done_s;
  logic                 busy_r, busy_s;

  rr_arb2 u_arb (
    .req  (req_i),
    .last (last_r),
    .gnt  (arb_gnt_s)
  );

  // next-state, grant, burst length and beat counter
  always_comb begin
    state_s = state_r;
    gnt_s   = gnt_r;
    len_s   = len_r;
    beat_s  = beat_r;
    last_s  = last_r;
    case (state_r)
      ST_IDLE: begin
        if (|req_i) begin
          gnt_s  = arb_gnt_s;
          len_s  = arb_gnt_s[REQ1] ? len1_i : len0_i;
          beat_s = LEN_ZERO;
          // a zero-length burst skips RUN and only clears the Counter
          if (len_s != LEN_ZERO) begin
            state_s = ST_RUN;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          gnt_s   = 2'b00;
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        beat_s = beat_r + LEN_ONE;
        if (beat_r == len_r - LEN_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        last_s  = gnt_r[REQ1];
        gnt_s   = 2'b00;
        state_s = ST_IDLE;
      end
      default: begin
        gnt_s   = 2'b00;
        state_s = ST_IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they leave a flop directly
  always_comb begin
    cnt_en_s   = (state_s == ST_RUN);
    cnt_done_s = (state_s == ST_DONE);
    done_s     = cnt_done_s ? gnt_s : 2'b00;
    busy_s     = (state_s != ST_IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      gnt_r      <= 2'b00;
      len_r      <= LEN_ZERO;
      beat_r     <= LEN_ZERO;
      last_r     <= REQ1;
      cnt_en_r   <= 1'b0;
      cnt_done_r <= 1'b0;
      done_r     <= 2'b00;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      gnt_r      <= gnt_s;
      len_r      <= len_s;
      beat_r     <= beat_s;
      last_r     <= last_s;
      cnt_en_r   <= cnt_en_s;
      cnt_done_r <= cnt_done_s;
      done_r     <= done_s;
      busy_r     <= busy_s;
    end
  end

  assign gnt_o      = gnt_r;
  assign cnt_en_o   = cnt_en_r;
  assign cnt_done_o = cnt_done_r;
  assign done_o     = done_r;
  assign busy_o     = busy_r;

endmodule
